// File: rtl/sramqsys_key_pio_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// Reads have zero wait states; readdata is combinational from address.
interface sramqsys_key_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/sramqsys_key_pio.sv
// Input PIO: synchronizes external lines, latches selected edges into a write-1-to-clear
// capture register, and raises a level interrupt for captures enabled in IRQMASK.
module sramqsys_key_pio #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned EDGE_TYPE = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sramqsys_key_pio_if.slave    bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   localparam logic [1:0] AddrData    = 2'd0;
   localparam logic [1:0] AddrIrqMask = 2'd2;
   localparam logic [1:0] AddrEdgeCap = 2'd3;

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edgecap;

   logic             w_wr;
   logic             w_wr_mask;
   logic             w_wr_cap;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_edgecap_d;
   logic [WIDTH-1:0] w_irqmask_d;

   assign w_wr      = bus.chipselect & ~bus.write_n;
   assign w_wr_mask = w_wr && (bus.address == AddrIrqMask);
   assign w_wr_cap  = w_wr && (bus.address == AddrEdgeCap);

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign w_edge = r_sync2 & ~r_prev;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign w_edge = ~r_sync2 & r_prev;
      end else begin : g_any
         assign w_edge = r_sync2 ^ r_prev;
      end
   endgenerate

   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic w_unused_wdata;
         assign w_unused_wdata = ^bus.writedata[31:WIDTH];
      end
   endgenerate

   // A new edge wins over a same-cycle clear so no event is lost between read and clear.
   always_comb begin
      w_clr       = w_wr_cap ? bus.writedata[WIDTH-1:0] : '0;
      w_edgecap_d = (r_edgecap & ~w_clr) | w_edge;
      w_irqmask_d = w_wr_mask ? bus.writedata[WIDTH-1:0] : r_irqmask;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_prev    <= '0;
         r_irqmask <= '0;
         r_edgecap <= '0;
      end else begin
         r_sync1   <= in_port;
         r_sync2   <= r_sync1;
         r_prev    <= r_sync2;
         r_irqmask <= w_irqmask_d;
         r_edgecap <= w_edgecap_d;
      end
   end

   always_comb begin
      bus.readdata = '0;
      unique case (bus.address)
         AddrData:    bus.readdata[WIDTH-1:0] = r_sync2;
         AddrIrqMask: bus.readdata[WIDTH-1:0] = r_irqmask;
         AddrEdgeCap: bus.readdata[WIDTH-1:0] = r_edgecap;
         default:     bus.readdata = '0;
      endcase
   end

   assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_sramqsys_key_pio.sv
// Directed bench for the key PIO: rising, falling and any-edge builds share one bus and in_port.
module tb_sramqsys_key_pio;
   localparam int unsigned W = 4;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic [W-1:0]  in_port = '0;
   logic [1:0]    bus_addr = '0;
   logic          bus_cs   = 1'b0;
   logic          bus_wn   = 1'b1;
   logic [31:0]   bus_wd   = '0;
   logic          irq0, irq1, irq2;

   sramqsys_key_pio_if bif0 ();
   sramqsys_key_pio_if bif1 ();
   sramqsys_key_pio_if bif2 ();

   assign bif0.address = bus_addr;
   assign bif0.chipselect = bus_cs;
   assign bif0.write_n = bus_wn;
   assign bif0.writedata = bus_wd;
   assign bif1.address = bus_addr;
   assign bif1.chipselect = bus_cs;
   assign bif1.write_n = bus_wn;
   assign bif1.writedata = bus_wd;
   assign bif2.address = bus_addr;
   assign bif2.chipselect = bus_cs;
   assign bif2.write_n = bus_wn;
   assign bif2.writedata = bus_wd;

   sramqsys_key_pio #(.WIDTH(W), .EDGE_TYPE(0)) dut_rise (
      .clk(clk), .reset_n(reset_n), .bus(bif0), .in_port(in_port), .irq(irq0));
   sramqsys_key_pio #(.WIDTH(W), .EDGE_TYPE(1)) dut_fall (
      .clk(clk), .reset_n(reset_n), .bus(bif1), .in_port(in_port), .irq(irq1));
   sramqsys_key_pio #(.WIDTH(W), .EDGE_TYPE(2)) dut_any (
      .clk(clk), .reset_n(reset_n), .bus(bif2), .in_port(in_port), .irq(irq2));

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_exp(string tag, logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic compare(logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_underflow observed=0x%0h required=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            n_bad++;
            $display("FAIL %s observed=0x%0h required=0x%0h", e.tag, obs, e.val);
            $error("%s differs", e.tag);
         end
      end
   endtask

   function automatic logic [31:0] rd_of(int d);
      case (d)
         0:       return bif0.readdata;
         1:       return bif1.readdata;
         default: return bif2.readdata;
      endcase
   endfunction

   function automatic logic irq_of(int d);
      case (d)
         0:       return irq0;
         1:       return irq1;
         default: return irq2;
      endcase
   endfunction

   task automatic chk_rd(int d, logic [1:0] a, string tag, logic [31:0] e);
      logic [31:0] v;
      push_exp(tag, e);
      bus_addr = a;
      bus_cs   = 1'b1;
      bus_wn   = 1'b1;
      #1;
      v = rd_of(d);
      bus_cs = 1'b0;
      compare(v);
   endtask

   task automatic chk_irq(int d, string tag, logic e);
      push_exp(tag, {31'd0, e});
      compare({31'd0, irq_of(d)});
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] dat);
      bus_addr = a;
      bus_wd   = dat;
      bus_cs   = 1'b1;
      bus_wn   = 1'b0;
      tick();
      bus_cs = 1'b0;
      bus_wn = 1'b1;
   endtask

   initial begin
      // Reset with inputs low: every register and irq read zero.
      #2;
      chk_rd(0, 2'd0, "rst_data", 32'h0);
      chk_rd(0, 2'd1, "rst_resv", 32'h0);
      chk_rd(0, 2'd2, "rst_mask", 32'h0);
      chk_rd(0, 2'd3, "rst_cap", 32'h0);
      chk_irq(0, "rst_irq", 1'b0);
      tick();
      reset_n = 1'b1;
      tick();

      // Level path: DATA follows two edges after in_port changes.
      in_port = 4'b0101;
      tick();
      chk_rd(0, 2'd0, "data_n", 32'h0);
      tick();
      chk_rd(0, 2'd0, "data_n1", 32'h5);
      chk_rd(0, 2'd3, "cap_n1", 32'h0);
      tick();
      chk_rd(0, 2'd3, "cap_n2", 32'h5);
      chk_irq(0, "irq_unmasked", 1'b0);
      wr(2'd0, 32'hF);
      wr(2'd1, 32'hF);
      chk_rd(0, 2'd0, "data_ro", 32'h5);
      chk_rd(0, 2'd1, "resv_ro", 32'h0);
      in_port = 4'b0000;
      ticks(3);
      wr(2'd3, 32'hF);
      chk_rd(0, 2'd3, "cap_clear_all", 32'h0);

      // Rising capture with full mask, then clear.
      wr(2'd2, 32'hF);
      in_port = 4'b0100;
      tick();
      chk_rd(0, 2'd3, "rise_n", 32'h0);
      tick();
      chk_irq(0, "rise_irq_n1", 1'b0);
      tick();
      chk_rd(0, 2'd3, "rise_n2", 32'h4);
      chk_irq(0, "rise_irq_n2", 1'b1);
      wr(2'd3, 32'h4);
      chk_rd(0, 2'd3, "rise_clr", 32'h0);
      chk_irq(0, "rise_irq_clr", 1'b0);

      // Mask filtering: capture without interrupt until mask enables it.
      wr(2'd2, 32'h1);
      in_port = 4'b1100;
      ticks(3);
      chk_rd(0, 2'd3, "mask_cap", 32'h8);
      chk_irq(0, "mask_irq_off", 1'b0);
      wr(2'd2, 32'h9);
      chk_irq(0, "mask_irq_on", 1'b1);
      chk_rd(0, 2'd2, "mask_rd", 32'h9);

      // Set and clear of bit 0 on the same edge: set wins.
      in_port = 4'b1101;
      tick();
      tick();
      wr(2'd3, 32'h1);
      chk_rd(0, 2'd3, "setclr", 32'h9);
      chk_irq(0, "setclr_irq", 1'b1);

      // Partial clear of a full capture register.
      in_port = 4'b0000;
      ticks(3);
      wr(2'd3, 32'hF);
      in_port = 4'b1111;
      ticks(3);
      chk_rd(0, 2'd3, "part_full", 32'hF);
      wr(2'd3, 32'h5);
      chk_rd(0, 2'd3, "part_clr", 32'hA);

      // Any-edge versus falling-only builds on a pulse of bit 1.
      in_port = 4'b0000;
      ticks(3);
      wr(2'd3, 32'hF);
      chk_rd(1, 2'd3, "fall_pre", 32'h0);
      in_port = 4'b0010;
      ticks(3);
      chk_rd(2, 2'd3, "any_rise", 32'h2);
      chk_rd(1, 2'd3, "fall_ign_rise", 32'h0);
      wr(2'd3, 32'h2);
      chk_rd(2, 2'd3, "any_clr", 32'h0);
      in_port = 4'b0000;
      ticks(3);
      chk_rd(2, 2'd3, "any_fall", 32'h2);
      chk_rd(1, 2'd3, "fall_fall", 32'h2);
      chk_rd(0, 2'd3, "rise_ign_fall", 32'h0);
      chk_irq(1, "fall_irq_masked", 1'b0);

      // Asynchronous reset between edges while irq is high.
      in_port = 4'b0001;
      ticks(3);
      chk_irq(0, "pre_rst_irq", 1'b1);
      #3;
      reset_n = 1'b0;
      #1;
      chk_irq(0, "mid_rst_irq", 1'b0);
      chk_rd(0, 2'd0, "mid_rst_data", 32'h0);
      chk_rd(0, 2'd2, "mid_rst_mask", 32'h0);
      chk_rd(0, 2'd3, "mid_rst_cap", 32'h0);
      chk_irq(2, "mid_rst_irq_any", 1'b0);
      #1;
      reset_n = 1'b1;

      // Input held high through reset yields one rising capture.
      tick();
      tick();
      chk_rd(0, 2'd0, "post_rst_data", 32'h1);
      chk_rd(0, 2'd3, "post_rst_cap_n1", 32'h0);
      tick();
      chk_rd(0, 2'd3, "post_rst_cap_n2", 32'h1);
      chk_irq(0, "post_rst_irq", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
